// File: rtl/bus_decoder_if.sv
// CPU-side and device-side signals of the system-bus chip-select decoder.
// The master modport is the CPU/device side; the slave modport is the decoder.
interface bus_decoder_if #(
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned N_REGIONS = 10
);
   logic [ADDR_W-1:0]           cpu_addr;
   logic                        cpu_req;
   logic                        cpu_we;
   logic [DATA_W-1:0]           cpu_rdata;
   logic                        cpu_ready;
   logic                        bus_err;
   logic                        busy;
   logic [N_REGIONS-1:0]        cs;
   logic                        dev_we;
   logic [N_REGIONS*DATA_W-1:0] dev_rdata;
   logic [3:0]                  region_id;

   modport master (
      output cpu_addr, cpu_req, cpu_we, dev_rdata,
      input  cpu_rdata, cpu_ready, bus_err, busy, cs, dev_we, region_id
   );

   modport slave (
      input  cpu_addr, cpu_req, cpu_we, dev_rdata,
      output cpu_rdata, cpu_ready, bus_err, busy, cs, dev_we, region_id
   );
endinterface

// File: rtl/bus_decoder.sv
// Base/mask chip-select decoder with per-region wait states, registered one-hot cs,
// read-data return mux and open-bus/error reporting for unmapped accesses.
module bus_decoder #(
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned N_REGIONS = 10,
   parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE = {
      16'hFFFF, 16'h9100, 16'h9090, 16'h9080, 16'h9000,
      16'hC000, 16'hA000, 16'h8000, 16'h0000, 16'hE000},
   parameter logic [N_REGIONS*ADDR_W-1:0] REGION_MASK = {
      16'h0000, 16'hFFE0, 16'hFFF0, 16'hFFF0, 16'hFF80,
      16'hE000, 16'hE000, 16'hF000, 16'h8000, 16'hE000},
   parameter logic [N_REGIONS*4-1:0]      REGION_WAIT = 40'h02_0000_0001,
   parameter logic [DATA_W-1:0]           OPEN_BUS    = 8'hFF
) (
   input logic           clk,
   input logic           reset,
   bus_decoder_if.slave  bus
);

   typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

   state_e               state_q, state_d;
   logic [N_REGIONS-1:0] cs_q, cs_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [3:0]           region_id_q, region_id_d;
   logic [DATA_W-1:0]    rdata_q, rdata_d;
   logic                 ready_q, ready_d;
   logic                 err_q, err_d;
   logic                 busy_q, busy_d;
   logic                 we_q, we_d;

   logic                 hit;
   logic [3:0]           hit_idx;
   logic [N_REGIONS-1:0] hit_oh;
   logic [3:0]           hit_wait;
   logic [DATA_W-1:0]    sel_rdata;

   // Scan from the top index down so the lowest matching region wins.
   always_comb begin
      hit      = 1'b0;
      hit_idx  = 4'h0;
      hit_oh   = '0;
      hit_wait = 4'h0;
      for (int i = int'(N_REGIONS) - 1; i >= 0; i--) begin
         logic [ADDR_W-1:0] base;
         logic [ADDR_W-1:0] mask;
         base = REGION_BASE[i*ADDR_W +: ADDR_W];
         mask = REGION_MASK[i*ADDR_W +: ADDR_W];
         if (!(mask == '0 && base != '0) && ((bus.cpu_addr & mask) == base)) begin
            hit       = 1'b1;
            hit_idx   = 4'(i);
            hit_oh    = '0;
            hit_oh[i] = 1'b1;
            hit_wait  = REGION_WAIT[i*4 +: 4];
         end
      end
   end

   always_comb begin
      sel_rdata = '0;
      for (int i = 0; i < int'(N_REGIONS); i++) begin
         if (region_id_q == 4'(i)) sel_rdata = bus.dev_rdata[i*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      state_d     = state_q;
      cs_d        = cs_q;
      cnt_d       = cnt_q;
      region_id_d = region_id_q;
      rdata_d     = rdata_q;
      ready_d     = 1'b0;
      err_d       = 1'b0;
      busy_d      = busy_q;
      we_d        = we_q;
      case (state_q)
         StIdle: begin
            if (bus.cpu_req) begin
               busy_d = 1'b1;
               we_d   = bus.cpu_we;
               if (hit) begin
                  cs_d        = hit_oh;
                  cnt_d       = hit_wait;
                  region_id_d = hit_idx;
                  state_d     = StAccess;
               end else begin
                  cs_d        = '0;
                  cnt_d       = 4'h0;
                  region_id_d = 4'hF;
                  state_d     = StDone;
               end
            end
         end
         StAccess: begin
            if (cnt_q != 4'h0) begin
               cnt_d = cnt_q - 4'h1;
            end else begin
               cs_d    = '0;
               ready_d = 1'b1;
               if (!we_q) rdata_d = sel_rdata;
               state_d = StDone;
            end
         end
         StDone: begin
            // Only the unmapped path arrives here with ready still low.
            if (!ready_q) begin
               ready_d = 1'b1;
               err_d   = 1'b1;
               if (!we_q) rdata_d = OPEN_BUS;
            end else begin
               busy_d  = 1'b0;
               we_d    = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         cs_q        <= '0;
         cnt_q       <= 4'h0;
         region_id_q <= 4'hF;
         rdata_q     <= '0;
         ready_q     <= 1'b0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         we_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         cs_q        <= cs_d;
         cnt_q       <= cnt_d;
         region_id_q <= region_id_d;
         rdata_q     <= rdata_d;
         ready_q     <= ready_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
         we_q        <= we_d;
      end
   end

   assign bus.cs        = cs_q;
   assign bus.dev_we    = we_q;
   assign bus.cpu_rdata = rdata_q;
   assign bus.cpu_ready = ready_q;
   assign bus.bus_err   = err_q;
   assign bus.busy      = busy_q;
   assign bus.region_id = region_id_q;

endmodule

// File: tb/tb_bus_decoder.sv
// Directed bench for bus_decoder: default map instance plus an instance with an
// overlapping region 6 and a 15-wait-state ROM.
module tb_bus_decoder;

   logic clk;
   logic reset;
   int   n_run;
   int   n_fail;

   bus_decoder_if #(.ADDR_W(16), .DATA_W(8), .N_REGIONS(10)) bi ();
   bus_decoder_if #(.ADDR_W(16), .DATA_W(8), .N_REGIONS(10)) bo ();

   bus_decoder u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bi)
   );

   bus_decoder #(
      .REGION_BASE ({16'hFFFF, 16'h9100, 16'h9090, 16'h9000, 16'h9000,
                     16'hC000, 16'hA000, 16'h8000, 16'h0000, 16'hE000}),
      .REGION_WAIT (40'h02_0000_000F)
   ) u_dut_ovl (
      .clk   (clk),
      .reset (reset),
      .bus   (bo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      n_run++; if (bi.cs !== 10'b0) begin n_fail++; $display("FAIL rst_cs: got %b expected 0", bi.cs); end
      n_run++; if (bi.cpu_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b expected 0", bi.cpu_ready); end
      n_run++; if (bi.bus_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b expected 0", bi.bus_err); end
      n_run++; if (bi.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", bi.busy); end
      n_run++; if (bi.cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_rdata: got %h expected 00", bi.cpu_rdata); end
      n_run++; if (bi.dev_we !== 1'b0) begin n_fail++; $display("FAIL rst_dev_we: got %b expected 0", bi.dev_we); end
      n_run++; if (bi.region_id !== 4'hF) begin n_fail++; $display("FAIL rst_region_id: got %h expected F", bi.region_id); end
      reset = 1'b0;
      step();
   endtask

   task automatic test_ram_read();
      bi.dev_rdata[1*8 +: 8] = 8'h5A;
      bi.cpu_addr = 16'h1234; bi.cpu_we = 1'b0; bi.cpu_req = 1'b1;
      step();
      bi.cpu_req = 1'b0;
      n_run++; if (bi.cs !== 10'b0000000010) begin n_fail++; $display("FAIL ram_cs: got %b expected 0000000010", bi.cs); end
      n_run++; if (bi.busy !== 1'b1) begin n_fail++; $display("FAIL ram_busy: got %b expected 1", bi.busy); end
      n_run++; if (bi.region_id !== 4'h1) begin n_fail++; $display("FAIL ram_region: got %h expected 1", bi.region_id); end
      n_run++; if (bi.cpu_ready !== 1'b0) begin n_fail++; $display("FAIL ram_early_ready: got %b expected 0", bi.cpu_ready); end
      step();
      n_run++; if (bi.cpu_ready !== 1'b1) begin n_fail++; $display("FAIL ram_ready: got %b expected 1", bi.cpu_ready); end
      n_run++; if (bi.cpu_rdata !== 8'h5A) begin n_fail++; $display("FAIL ram_rdata: got %h expected 5A", bi.cpu_rdata); end
      n_run++; if (bi.bus_err !== 1'b0) begin n_fail++; $display("FAIL ram_err: got %b expected 0", bi.bus_err); end
      n_run++; if (bi.cs !== 10'b0) begin n_fail++; $display("FAIL ram_cs_off: got %b expected 0", bi.cs); end
      step();
      n_run++; if ({bi.cpu_ready, bi.busy} !== 2'b00) begin n_fail++; $display("FAIL ram_end: got ready,busy=%b expected 00", {bi.cpu_ready, bi.busy}); end
   endtask

   task automatic test_rom_read();
      bi.dev_rdata[0*8 +: 8] = 8'hC3;
      bi.cpu_addr = 16'hE010; bi.cpu_we = 1'b0; bi.cpu_req = 1'b1;
      step();
      bi.cpu_req = 1'b0;
      for (int k = 1; k <= 2; k++) begin
         n_run++; if (bi.cs !== 10'b0000000001 || bi.cpu_ready !== 1'b0) begin
            n_fail++; $display("FAIL rom_cs T+%0d: got cs=%b ready=%b expected cs=0000000001 ready=0", k, bi.cs, bi.cpu_ready);
         end
         if (k == 1) step();
      end
      step();
      n_run++; if (bi.cpu_ready !== 1'b1) begin n_fail++; $display("FAIL rom_ready: got %b expected 1", bi.cpu_ready); end
      n_run++; if (bi.cpu_rdata !== 8'hC3) begin n_fail++; $display("FAIL rom_rdata: got %h expected C3", bi.cpu_rdata); end
      n_run++; if (bi.cs !== 10'b0) begin n_fail++; $display("FAIL rom_cs_off: got %b expected 0", bi.cs); end
      step();
   endtask

   task automatic test_unmapped();
      bi.cpu_addr = 16'h9200; bi.cpu_we = 1'b0; bi.cpu_req = 1'b1;
      step();
      bi.cpu_req = 1'b0;
      n_run++; if (bi.cs !== 10'b0 || bi.busy !== 1'b1 || bi.cpu_ready !== 1'b0) begin
         n_fail++; $display("FAIL unm_t1: got cs=%b busy=%b ready=%b expected 0,1,0", bi.cs, bi.busy, bi.cpu_ready);
      end
      n_run++; if (bi.region_id !== 4'hF) begin n_fail++; $display("FAIL unm_region: got %h expected F", bi.region_id); end
      step();
      n_run++; if (bi.cpu_ready !== 1'b1) begin n_fail++; $display("FAIL unm_ready: got %b expected 1", bi.cpu_ready); end
      n_run++; if (bi.bus_err !== 1'b1) begin n_fail++; $display("FAIL unm_err: got %b expected 1", bi.bus_err); end
      n_run++; if (bi.cpu_rdata !== 8'hFF) begin n_fail++; $display("FAIL unm_rdata: got %h expected FF", bi.cpu_rdata); end
      n_run++; if (bi.cs !== 10'b0) begin n_fail++; $display("FAIL unm_cs: got %b expected 0", bi.cs); end
      step();
      n_run++; if ({bi.cpu_ready, bi.bus_err, bi.busy} !== 3'b000) begin
         n_fail++; $display("FAIL unm_end: got ready,err,busy=%b expected 000", {bi.cpu_ready, bi.bus_err, bi.busy});
      end
   endtask

   task automatic test_pokey_write();
      int pulses;
      bi.cpu_addr = 16'h9105; bi.cpu_we = 1'b1; bi.cpu_req = 1'b1;
      step();
      bi.cpu_req = 1'b0;
      // Changing address/we mid-access must not disturb the latched decode.
      bi.cpu_addr = 16'h1234; bi.cpu_we = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         n_run++; if (bi.cs !== 10'b0100000000 || bi.dev_we !== 1'b1 || bi.cpu_ready !== 1'b0) begin
            n_fail++; $display("FAIL pokey_cs T+%0d: got cs=%b we=%b ready=%b expected 0100000000,1,0", k, bi.cs, bi.dev_we, bi.cpu_ready);
         end
         bi.cpu_req = (k == 2);
         step();
      end
      bi.cpu_req = 1'b0;
      n_run++; if (bi.cpu_ready !== 1'b1 || bi.cs !== 10'b0) begin
         n_fail++; $display("FAIL pokey_ready: got ready=%b cs=%b expected 1,0", bi.cpu_ready, bi.cs);
      end
      n_run++; if (bi.cpu_rdata !== 8'hFF) begin n_fail++; $display("FAIL pokey_rdata_hold: got %h expected FF", bi.cpu_rdata); end
      n_run++; if (bi.bus_err !== 1'b0) begin n_fail++; $display("FAIL pokey_err: got %b expected 0", bi.bus_err); end
      pulses = 0;
      for (int k = 0; k < 5; k++) begin
         step();
         if (bi.cpu_ready === 1'b1 || bi.busy === 1'b1 || bi.cs !== 10'b0) pulses++;
      end
      n_run++; if (pulses !== 0) begin n_fail++; $display("FAIL pokey_req_ignored: got %0d active cycles expected 0", pulses); end
   endtask

   task automatic test_back_to_back();
      logic exp_ready;
      bi.dev_rdata[1*8 +: 8] = 8'h66;
      bi.cpu_addr = 16'h0040; bi.cpu_we = 1'b0; bi.cpu_req = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         step();
         exp_ready = ((k % 3) == 2);
         n_run++; if (bi.cpu_ready !== exp_ready) begin
            n_fail++; $display("FAIL b2b_ready T+%0d: got %b expected %b", k, bi.cpu_ready, exp_ready);
         end
      end
      bi.cpu_req = 1'b0;
      step();
      step();
      step();
   endtask

   task automatic test_overlap();
      bo.dev_rdata[5*8 +: 8] = 8'h95;
      bo.dev_rdata[6*8 +: 8] = 8'h96;
      bo.cpu_addr = 16'h9000; bo.cpu_we = 1'b0; bo.cpu_req = 1'b1;
      step();
      bo.cpu_req = 1'b0;
      n_run++; if (bo.cs !== 10'b0000100000) begin n_fail++; $display("FAIL ovl_cs: got %b expected 0000100000", bo.cs); end
      n_run++; if (bo.region_id !== 4'h5) begin n_fail++; $display("FAIL ovl_region: got %h expected 5", bo.region_id); end
      step();
      n_run++; if (bo.cpu_ready !== 1'b1 || bo.cpu_rdata !== 8'h95) begin
         n_fail++; $display("FAIL ovl_rdata: got ready=%b rdata=%h expected 1,95", bo.cpu_ready, bo.cpu_rdata);
      end
      step();
   endtask

   task automatic test_reset_mid();
      int pulses;
      bo.cpu_addr = 16'hE000; bo.cpu_we = 1'b0; bo.cpu_req = 1'b1;
      step();
      bo.cpu_req = 1'b0;
      for (int k = 1; k <= 4; k++) step();
      n_run++; if (bo.cs !== 10'b0000000001 || bo.busy !== 1'b1) begin
         n_fail++; $display("FAIL rmid_t5: got cs=%b busy=%b expected 0000000001,1", bo.cs, bo.busy);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_run++; if (bo.cs !== 10'b0 || bo.busy !== 1'b0 || bo.cpu_ready !== 1'b0 || bo.bus_err !== 1'b0) begin
         n_fail++; $display("FAIL rmid_t6: got cs=%b busy=%b ready=%b err=%b expected 0,0,0,0", bo.cs, bo.busy, bo.cpu_ready, bo.bus_err);
      end
      pulses = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (bo.cpu_ready === 1'b1 || bo.cs !== 10'b0) pulses++;
      end
      n_run++; if (pulses !== 0) begin n_fail++; $display("FAIL rmid_no_ready: got %0d active cycles expected 0", pulses); end
      bo.dev_rdata[1*8 +: 8] = 8'h3C;
      bo.cpu_addr = 16'h0000; bo.cpu_req = 1'b1;
      step();
      bo.cpu_req = 1'b0;
      n_run++; if (bo.cs !== 10'b0000000010) begin n_fail++; $display("FAIL rmid_next_cs: got %b expected 0000000010", bo.cs); end
      step();
      n_run++; if (bo.cpu_ready !== 1'b1 || bo.cpu_rdata !== 8'h3C) begin
         n_fail++; $display("FAIL rmid_next_rdata: got ready=%b rdata=%h expected 1,3C", bo.cpu_ready, bo.cpu_rdata);
      end
      step();
   endtask

   initial begin
      n_run  = 0;
      n_fail = 0;
      reset  = 1'b1;
      bi.cpu_addr = '0; bi.cpu_req = 1'b0; bi.cpu_we = 1'b0;
      bo.cpu_addr = '0; bo.cpu_req = 1'b0; bo.cpu_we = 1'b0;
      for (int i = 0; i < 10; i++) begin
         bi.dev_rdata[i*8 +: 8] = 8'(8'h10 + i);
         bo.dev_rdata[i*8 +: 8] = 8'(8'h20 + i);
      end
      test_reset();
      test_ram_read();
      test_rom_read();
      test_unmapped();
      test_pokey_write();
      test_back_to_back();
      test_overlap();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
